// File: rtl/ogr_host_link.sv
// ogr_host_link: host byte-stream front end for mark_counter_assembly.
//  The host loads the starting marks ('L'), starts a search ('S') or aborts it ('A').
//  When the assembly raises done, the result count and stored rulers are latched
//  and streamed back as A5, count, then 2 bytes per mark (low byte first).
// Ports:
//  FXCLK, RESET_IN        clock, async active-low reset
//  rx_data/valid/ready    host -> block byte stream
//  tx_data/valid/ready    block -> host byte stream
//  firstvalues            preset marks {fv[0]..fv[N]} to the assembly
//  search_reset           active-high reset to the assembly
//  done, numResultsObserved, results   assembly status and result slots
//  busy                   high while searching or transmitting
module ogr_host_link #(
  parameter int NUMPOSITIONS = 5,
  parameter int POSBITS      = 9,
  parameter int NUMRESULTS   = 5
) (
  input  logic                                         FXCLK,
  input  logic                                         RESET_IN,
  input  logic [7:0]                                   rx_data,
  input  logic                                         rx_valid,
  output logic                                         rx_ready,
  output logic [7:0]                                   tx_data,
  output logic                                         tx_valid,
  input  logic                                         tx_ready,
  output logic [(NUMPOSITIONS+1)*POSBITS-1:0]          firstvalues,
  output logic                                         search_reset,
  input  logic                                         done,
  input  logic [5:0]                                   numResultsObserved,
  input  logic [(NUMPOSITIONS+1)*POSBITS*NUMRESULTS-1:0] results,
  output logic                                         busy
);

  localparam int NM  = NUMPOSITIONS + 1;
  localparam int RW  = NM * POSBITS;
  localparam int LDB = 2 * NM;
  localparam int LDW = $clog2(LDB);
  localparam int MW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int RIW = (NUMRESULTS > 1) ? $clog2(NUMRESULTS) : 1;

  localparam logic [7:0] CMD_L = 8'h4C;
  localparam logic [7:0] CMD_S = 8'h53;
  localparam logic [7:0] CMD_A = 8'h41;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_SEARCH, S_TX_HDR, S_TX_CNT, S_TX_DATA, S_TX_ABT
  } state_e;

  state_e state_q, state_d;

  logic                 srst_q;
  logic [LDW-1:0]       ld_cnt_q;
  logic [15:0]          sh_q  [NM];               // load shadow, full 16b per mark
  logic [POSBITS-1:0]   fv_q  [NM];
  logic [POSBITS-1:0]   res_q [NUMRESULTS][NM];   // latched result slots
  logic [5:0]           cnt_q;
  logic [RIW-1:0]       rlast_q;                  // index of last slot to send
  logic [RIW-1:0]       ridx_q;
  logic [MW-1:0]        midx_q;
  logic                 hb_q;                     // 0: low byte, 1: high byte

  logic rx_fire, tx_fire;
  logic start_take, done_take, abort_take, ld_last, dat_last;
  logic [15:0] last16, m16;

  assign rx_ready = (state_q == S_IDLE) || (state_q == S_LOAD) || (state_q == S_SEARCH);
  assign tx_valid = (state_q == S_TX_HDR) || (state_q == S_TX_CNT) ||
                    (state_q == S_TX_DATA) || (state_q == S_TX_ABT);
  assign busy     = (state_q == S_SEARCH) || tx_valid;
  assign search_reset = srst_q;

  assign rx_fire    = rx_valid && rx_ready;
  assign tx_fire    = tx_valid && tx_ready;
  assign start_take = (state_q == S_IDLE) && rx_fire && (rx_data == CMD_S);
  assign done_take  = (state_q == S_SEARCH) && done;
  // done has priority over a same-cycle abort
  assign abort_take = (state_q == S_SEARCH) && rx_fire && (rx_data == CMD_A) && !done;
  assign ld_last    = (state_q == S_LOAD) && rx_fire && (ld_cnt_q == LDW'(LDB - 1));
  assign dat_last   = hb_q && (midx_q == MW'(NUMPOSITIONS)) && (ridx_q == rlast_q);
  assign last16     = {rx_data, sh_q[NUMPOSITIONS][7:0]};
  assign m16        = 16'(res_q[ridx_q][midx_q]);

  for (genvar g = 0; g < NM; g++) begin : g_fv
    assign firstvalues[(NM-g)*POSBITS-1 -: POSBITS] = fv_q[g];
  end

  always_comb begin
    tx_data = 8'h00;
    unique case (state_q)
      S_TX_HDR:  tx_data = 8'hA5;
      S_TX_CNT:  tx_data = {2'b00, cnt_q};
      S_TX_DATA: tx_data = hb_q ? m16[15:8] : m16[7:0];
      S_TX_ABT:  tx_data = 8'hAB;
      default:   tx_data = 8'h00;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: if (rx_fire) begin
        if (rx_data == CMD_L)      state_d = S_LOAD;
        else if (rx_data == CMD_S) state_d = S_SEARCH;
      end
      S_LOAD:    if (ld_last) state_d = S_IDLE;
      S_SEARCH:  if (done_take) state_d = S_TX_HDR;
                 else if (abort_take) state_d = S_TX_ABT;
      S_TX_HDR:  if (tx_fire) state_d = S_TX_CNT;
      S_TX_CNT:  if (tx_fire) state_d = (cnt_q == 6'd0) ? S_IDLE : S_TX_DATA;
      S_TX_DATA: if (tx_fire && dat_last) state_d = S_IDLE;
      S_TX_ABT:  if (tx_fire) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge FXCLK or negedge RESET_IN) begin
    if (!RESET_IN) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_ff @(posedge FXCLK or negedge RESET_IN) begin
    if (!RESET_IN) begin
      srst_q   <= 1'b1;
      ld_cnt_q <= '0;
      cnt_q    <= '0;
      rlast_q  <= '0;
      ridx_q   <= '0;
      midx_q   <= '0;
      hb_q     <= 1'b0;
      for (int i = 0; i < NM; i++) begin
        fv_q[i] <= POSBITS'(i);
        sh_q[i] <= '0;
      end
      for (int k = 0; k < NUMRESULTS; k++)
        for (int i = 0; i < NM; i++)
          res_q[k][i] <= '0;
    end else begin
      if (start_take)                    srst_q <= 1'b0;
      else if (done_take || abort_take)  srst_q <= 1'b1;

      // shadow collects bytes; firstvalues only moves on the final byte
      if (state_q == S_IDLE) ld_cnt_q <= '0;
      else if ((state_q == S_LOAD) && rx_fire) begin
        ld_cnt_q <= ld_cnt_q + LDW'(1);
        if (!ld_cnt_q[0]) sh_q[ld_cnt_q[LDW-1:1]][7:0]  <= rx_data;
        else              sh_q[ld_cnt_q[LDW-1:1]][15:8] <= rx_data;
        if (ld_last) begin
          for (int i = 0; i < NUMPOSITIONS; i++) fv_q[i] <= sh_q[i][POSBITS-1:0];
          fv_q[NUMPOSITIONS] <= last16[POSBITS-1:0];
        end
      end

      if (done_take) begin
        cnt_q <= numResultsObserved;
        if (numResultsObserved >= 6'(NUMRESULTS)) rlast_q <= RIW'(NUMRESULTS - 1);
        else                                      rlast_q <= RIW'(numResultsObserved - 6'd1);
        for (int k = 0; k < NUMRESULTS; k++)
          for (int i = 0; i < NM; i++)
            res_q[k][i] <= results[(NUMRESULTS-k)*RW - 1 - i*POSBITS -: POSBITS];
      end

      if (state_q == S_TX_CNT) begin
        hb_q   <= 1'b0;
        midx_q <= '0;
        ridx_q <= '0;
      end else if ((state_q == S_TX_DATA) && tx_fire) begin
        if (!hb_q) hb_q <= 1'b1;
        else begin
          hb_q <= 1'b0;
          if (midx_q == MW'(NUMPOSITIONS)) begin
            midx_q <= '0;
            ridx_q <= ridx_q + RIW'(1);
          end else begin
            midx_q <= midx_q + MW'(1);
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ogr_host_link.sv
module tb_ogr_host_link;
  localparam int N   = 5;
  localparam int PB  = 9;
  localparam int NR  = 5;
  localparam int NM  = N + 1;
  localparam int RW  = NM * PB;
  localparam int FVW = NM * PB;

  logic FXCLK = 1'b0;
  always #5 FXCLK = ~FXCLK;

  logic               RESET_IN;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic               rx_ready;
  logic [7:0]         tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [FVW-1:0]     firstvalues;
  logic               search_reset;
  logic               done;
  logic [5:0]         numResultsObserved;
  logic [RW*NR-1:0]   results;
  logic               busy;

  ogr_host_link #(.NUMPOSITIONS(N), .POSBITS(PB), .NUMRESULTS(NR)) dut (
    .FXCLK(FXCLK), .RESET_IN(RESET_IN),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .firstvalues(firstvalues), .search_reset(search_reset),
    .done(done), .numResultsObserved(numResultsObserved), .results(results),
    .busy(busy)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [7:0] exp_q[$];
  bit stall_en = 1'b0;
  int rm [1:NR][0:N];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s", nm);
  endtask

  function automatic logic [FVW-1:0] pack6(input int a0, a1, a2, a3, a4, a5);
    int a[6];
    logic [FVW-1:0] r;
    a = '{a0, a1, a2, a3, a4, a5};
    r = '0;
    for (int i = 0; i < NM; i++) r[(NM-i)*PB-1 -: PB] = PB'(a[i]);
    return r;
  endfunction

  task automatic pack_results();
    for (int k = 1; k <= NR; k++)
      for (int i = 0; i < NM; i++)
        results[(NR-k+1)*RW - 1 - i*PB -: PB] = PB'(rm[k][i]);
  endtask

  task automatic push_stream(input int cnt);
    int n;
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'(cnt));
    n = (cnt > NR) ? NR : cnt;
    for (int k = 1; k <= n; k++)
      for (int i = 0; i < NM; i++) begin
        exp_q.push_back(8'(rm[k][i] & 255));
        exp_q.push_back(8'((rm[k][i] >> 8) & 255));
      end
  endtask

  task automatic send(input logic [7:0] b);
    int t;
    @(negedge FXCLK);
    rx_data  = b;
    rx_valid = 1'b1;
    t = 0;
    while (!rx_ready && t < 200) begin
      @(negedge FXCLK);
      t++;
    end
    if (!rx_ready) fail("rx_timeout");
    @(posedge FXCLK);
    #1 rx_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int t;
    t = 0;
    @(negedge FXCLK);
    while ((exp_q.size() != 0 || busy) && t < 3000) begin
      @(negedge FXCLK);
      t++;
    end
    if (t >= 3000) fail({nm, "_timeout"});
    check({nm, "_drained"}, 64'(exp_q.size()), 64'd0);
    check({nm, "_txv_idle"}, 64'(tx_valid), 64'd0);
  endtask

  // Start, let the model assembly run 50 cycles, then report cnt results.
  task automatic run_search(input string nm, input int cnt);
    push_stream(cnt);
    pack_results();
    send(8'h53);
    check({nm, "_srst_start"}, 64'(search_reset), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd1);
    repeat (49) @(posedge FXCLK);
    #1 check({nm, "_srst_window"}, 64'(search_reset), 64'd0);
    @(negedge FXCLK);
    done = 1'b1;
    numResultsObserved = 6'(cnt);
    @(posedge FXCLK);
    #1 done = 1'b0;
    results = '1;                 // assembly moves on; latched copy must hold
    numResultsObserved = 6'd0;
    check({nm, "_srst_done"}, 64'(search_reset), 64'd1);
    check({nm, "_hdr_valid"}, 64'(tx_valid), 64'd1);
    wait_idle(nm);
  endtask

  task automatic set_t3();
    rm[1] = '{0, 1, 4, 10, 12, 17};
  endtask

  // tx_ready driver
  initial begin
    tx_ready = 1'b1;
    forever begin
      @(posedge FXCLK);
      #1 tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // monitor / scoreboard
  initial begin
    logic held;
    logic [7:0] hd, e;
    held = 1'b0;
    hd = 8'h00;
    forever begin
      @(negedge FXCLK);
      if (held) begin
        check("stall_valid", 64'(tx_valid), 64'd1);
        check("stall_data", 64'(tx_data), 64'(hd));
      end
      held = tx_valid && !tx_ready;
      hd   = tx_data;
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_tx: got %0h, expected no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          check("tx_byte", 64'(tx_data), 64'(e));
        end
      end
    end
  end

  initial begin
    RESET_IN = 1'b0;
    rx_data = 8'h00;
    rx_valid = 1'b0;
    done = 1'b0;
    numResultsObserved = 6'd0;
    results = '0;
    for (int k = 1; k <= NR; k++)
      for (int i = 0; i < NM; i++) rm[k][i] = 0;

    // reset state
    repeat (3) @(negedge FXCLK);
    check("rst_fv", 64'(firstvalues), 64'(pack6(0, 1, 2, 3, 4, 5)));
    check("rst_srst", 64'(search_reset), 64'd1);
    check("rst_txv", 64'(tx_valid), 64'd0);
    check("rst_txd", 64'(tx_data), 64'd0);
    check("rst_rxr", 64'(rx_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    RESET_IN = 1'b1;

    // junk byte in IDLE is dropped silently
    send(8'h11);

    // load {0,1,2,3,5,7}
    send(8'h4C);
    send(8'h00); send(8'h00); send(8'h01); send(8'h00); send(8'h02); send(8'h00);
    send(8'h03); send(8'h00); send(8'h05); send(8'h00); send(8'h07);
    check("load_hold12", 64'(firstvalues), 64'(pack6(0, 1, 2, 3, 4, 5)));
    send(8'h00);
    check("load_done13", 64'(firstvalues), 64'(pack6(0, 1, 2, 3, 5, 7)));

    // one result
    set_t3();
    run_search("t3", 1);

    // count above slot count: only NR results sent
    for (int k = 1; k <= NR; k++)
      for (int i = 0; i < NM; i++) rm[k][i] = k * 20 + i * 80;
    run_search("t4", 7);

    // same as t3 with random back-pressure
    set_t3();
    stall_en = 1'b1;
    run_search("t5", 1);
    stall_en = 1'b0;

    // abort
    exp_q.push_back(8'hAB);
    send(8'h53);
    check("abt_srst_start", 64'(search_reset), 64'd0);
    repeat (5) @(posedge FXCLK);
    send(8'h41);
    check("abt_srst", 64'(search_reset), 64'd1);
    wait_idle("abt");

    // restart; done and 'A' in the same cycle, count 0: A5,00 only
    push_stream(0);
    send(8'h53);
    check("rs_srst", 64'(search_reset), 64'd0);
    @(negedge FXCLK);
    done = 1'b1;
    numResultsObserved = 6'd0;
    rx_data = 8'h41;
    rx_valid = 1'b1;
    @(posedge FXCLK);
    #1 done = 1'b0;
    rx_valid = 1'b0;
    check("rs_srst_done", 64'(search_reset), 64'd1);
    wait_idle("rs");

    // reset in the middle of a load
    send(8'h4C); send(8'h09); send(8'h00); send(8'h09);
    @(negedge FXCLK);
    RESET_IN = 1'b0;
    #1;
    check("mid_rst_fv", 64'(firstvalues), 64'(pack6(0, 1, 2, 3, 4, 5)));
    check("mid_rst_srst", 64'(search_reset), 64'd1);
    check("mid_rst_rxr", 64'(rx_ready), 64'd1);
    @(negedge FXCLK);
    RESET_IN = 1'b1;

    // fresh load after reset: high bytes used, bits above POSBITS dropped
    send(8'h4C);
    send(8'h00); send(8'h00); send(8'h02); send(8'h00); send(8'h04); send(8'h00);
    send(8'h06); send(8'h00); send(8'h2C); send(8'h01); send(8'h05); send(8'hFF);
    check("reload_fv", 64'(firstvalues), 64'(pack6(0, 2, 4, 6, 300, 261)));

    repeat (5) @(negedge FXCLK);
    check("final_q_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
